fpu_div_rtl: RTL and testbench



---
 rtl/fpu_div_rtl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fpu_div_rtl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fpu_div_rtl.sv
// Multi-cycle IEEE-754 binary32 divider (radix-2 restoring), fixed 30-cycle latency.
// Optional `FPU_DIV_FLAGS_EN` adds a flags[4:0] = {invalid, divzero, overflow, underflow, inexact} port.
module fpu_div_rtl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        valid,
  output logic [31:0] result,
  output logic        ready
`ifdef FPU_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [4:0]         lza_q, lza_d, lzb_q, lzb_d;
  logic               sign_q, sign_d;
  logic               special_q, special_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d;
  logic [25:0]        rem_q, rem_d, quo_q, quo_d;
  logic [23:0]        mant_q, mant_d;
  logic               g_q, g_d, s_q, s_d;
  logic [31:0]        result_q, result_d;
`ifdef FPU_DIV_FLAGS_EN
  logic [1:0]         spec_flg_q, spec_flg_d;
  logic [4:0]         flags_q, flags_d;
`endif

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Round-to-nearest-even on a normalized 24-bit mantissa; returns {exp, frac}.
  function automatic logic [32:0] rne_round(input logic [23:0] mant, input logic g,
                                            input logic s, input logic signed [9:0] e);
    logic              inc;
    logic [24:0]       sum;
    logic signed [9:0] eo;
    logic [22:0]       frac;
    inc = g & (s | mant[0]);
    sum = {1'b0, mant} + {24'd0, inc};
    if (sum[24]) begin
      eo   = e + 10'sd1;
      frac = sum[23:1];
    end else begin
      eo   = e;
      frac = sum[22:0];
    end
    return {eo, frac};
  endfunction

  function automatic logic [31:0] sat_pack(input logic sign, input logic signed [9:0] e,
                                           input logic [22:0] frac);
    if (e >= 10'sd255)     return {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0)  return {sign, 31'd0};
    else                   return {sign, e[7:0], frac};
  endfunction

  logic [7:0]        a_exp, b_exp;
  logic [22:0]       a_frac, b_frac;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic signed [9:0] ea_eff, eb_eff;
  logic [23:0]       ma_n, mb_n;
  logic              ge;
  logic [25:0]       rem_sub;
  logic [32:0]       rnd;
  logic signed [9:0] rnd_exp;
  logic [22:0]       rnd_frac;

  assign a_exp  = a_q[30:23];
  assign b_exp  = b_q[30:23];
  assign a_frac = a_q[22:0];
  assign b_frac = b_q[22:0];
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_zero = (a_exp == 8'h00) && (a_frac == 23'd0);
  assign b_zero = (b_exp == 8'h00) && (b_frac == 23'd0);
  assign sgn    = a_q[31] ^ b_q[31];

  // Subnormals get their leading zeros shifted out, leaving an effective exponent below 1.
  assign ma_n   = {(a_exp != 8'h00), a_frac} << lza_q;
  assign mb_n   = {(b_exp != 8'h00), b_frac} << lzb_q;
  assign ea_eff = (a_exp == 8'h00) ? (10'sd1 - $signed({5'd0, lza_q})) : $signed({2'b00, a_exp});
  assign eb_eff = (b_exp == 8'h00) ? (10'sd1 - $signed({5'd0, lzb_q})) : $signed({2'b00, b_exp});

  assign ge      = rem_q >= {2'b00, mb_q};
  assign rem_sub = ge ? (rem_q - {2'b00, mb_q}) : rem_q;

  assign rnd      = rne_round(mant_q, g_q, s_q, exp_q);
  assign rnd_exp  = $signed(rnd[32:23]);
  assign rnd_frac = rnd[22:0];

`ifdef FPU_DIV_FLAGS_EN
  logic invalid_c, divzero_c, ovf_c, unf_c;
  assign invalid_c = (a_nan & ~a_frac[22]) | (b_nan & ~b_frac[22]) |
                     (a_zero & b_zero) | (a_inf & b_inf);
  assign divzero_c = b_zero & ~a_zero & ~a_inf & ~a_nan;
  assign ovf_c     = rnd_exp >= 10'sd255;
  assign unf_c     = rnd_exp <= 10'sd0;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    lza_d      = lza_q;
    lzb_d      = lzb_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    exp_d      = exp_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    mant_d     = mant_q;
    g_d        = g_q;
    s_d        = s_q;
    result_d   = result_q;
`ifdef FPU_DIV_FLAGS_EN
    spec_flg_d = spec_flg_q;
    flags_d    = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          a_d     = din1;
          b_d     = din2;
          phase_d = 1'b0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (!phase_q) begin
          lza_d     = (a_exp == 8'h00) ? lzc24({1'b0, a_frac}) : 5'd0;
          lzb_d     = (b_exp == 8'h00) ? lzc24({1'b0, b_frac}) : 5'd0;
          sign_d    = sgn;
          special_d = 1'b1;
          if (a_nan || b_nan)                        spec_res_d = QNAN;
          else if ((a_zero && b_zero) || (a_inf && b_inf)) spec_res_d = QNAN;
          else if (b_zero || a_inf)                  spec_res_d = {sgn, 8'hFF, 23'd0};
          else if (a_zero || b_inf)                  spec_res_d = {sgn, 31'd0};
          else begin
            special_d  = 1'b0;
            spec_res_d = 32'h0;
          end
`ifdef FPU_DIV_FLAGS_EN
          spec_flg_d = {invalid_c, divzero_c};
`endif
          phase_d = 1'b1;
        end else begin
          ma_d    = ma_n;
          mb_d    = mb_n;
          exp_d   = ea_eff - eb_eff + 10'sd127;
          rem_d   = {2'b00, ma_n};
          quo_d   = 26'd0;
          cnt_d   = 5'd0;
          phase_d = 1'b0;
          state_d = S_DIVIDE;
        end
      end
      // One restoring step per cycle: quotient bits 25 down to 0.
      S_DIVIDE: begin
        rem_d = rem_sub << 1;
        quo_d = {quo_q[24:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (!phase_q) begin
          if (quo_q[25]) begin
            mant_d = quo_q[25:2];
            g_d    = quo_q[1];
            s_d    = quo_q[0] | (rem_q != 26'd0);
          end else begin
            mant_d = quo_q[24:1];
            g_d    = quo_q[0];
            s_d    = rem_q != 26'd0;
            exp_d  = exp_q - 10'sd1;
          end
          phase_d = 1'b1;
        end else begin
          result_d = special_q ? spec_res_q : sat_pack(sign_q, rnd_exp, rnd_frac);
`ifdef FPU_DIV_FLAGS_EN
          flags_d = special_q ? {spec_flg_q, 3'b000}
                              : {2'b00, ovf_c, unf_c, g_q | s_q | ovf_c | unf_c};
`endif
          phase_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= 5'd0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      lza_q      <= 5'd0;
      lzb_q      <= 5'd0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= 32'h0;
      exp_q      <= 10'sd0;
      ma_q       <= 24'd0;
      mb_q       <= 24'd0;
      rem_q      <= 26'd0;
      quo_q      <= 26'd0;
      mant_q     <= 24'd0;
      g_q        <= 1'b0;
      s_q        <= 1'b0;
      result_q   <= 32'h0;
`ifdef FPU_DIV_FLAGS_EN
      spec_flg_q <= 2'b00;
      flags_q    <= 5'd0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      lza_q      <= lza_d;
      lzb_q      <= lzb_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      exp_q      <= exp_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      mant_q     <= mant_d;
      g_q        <= g_d;
      s_q        <= s_d;
      result_q   <= result_d;
`ifdef FPU_DIV_FLAGS_EN
      spec_flg_q <= spec_flg_d;
      flags_q    <= flags_d;
`endif
    end
  end

  assign result = result_q;
  assign ready  = (state_q == S_DONE);
`ifdef FPU_DIV_FLAGS_EN
  assign flags  = flags_q;
`endif

endmodule

// File: tb/tb_fpu_div_rtl.sv
// Directed bench for fpu_div_rtl: latency, pulse width, arithmetic, specials, reset and busy behaviour.
module tb_fpu_div_rtl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] din1, din2;
  logic [31:0] result;
  logic        ready;
`ifdef FPU_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_div_rtl dut (
    .clk    (clk),
    .reset  (reset),
    .din1   (din1),
    .din2   (din2),
    .valid  (valid),
    .result (result),
    .ready  (ready)
`ifdef FPU_DIV_FLAGS_EN
    ,
    .flags  (flags)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    din1  = a;
    din2  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Counts negedges until ready is seen, giving up after 40.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ready) break;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    int n;
    start(a, b);
    wait_ready(n);
    check32({tag, " latency"}, 32'(n), 32'd30);
    check32(tag, result, exp);
    @(negedge clk);
    check32({tag, " pulse"}, {31'd0, ready}, 32'd0);
    check32({tag, " hold"}, result, exp);
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b0;
    valid = 1'b0;
    din1  = 32'h0;
    din2  = 32'h0;
    repeat (3) @(negedge clk);
    check32("reset result", result, 32'h0);
    check32("reset ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;

    run("1/2",       32'h3f800000, 32'h40000000, 32'h3f000000);
    run("3.5/1.75",  32'h40600000, 32'h3fe00000, 32'h40000000);
    run("7/2",       32'h40e00000, 32'h40000000, 32'h40600000);
    run("-5.5/2",    32'hc0b00000, 32'h40000000, 32'hc0300000);

    // Abandon an operation partway through the divide loop.
    start(32'h40e00000, 32'h40000000);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check32("midreset result", result, 32'h0);
    check32("midreset ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check32("midreset no pulse", 32'(pulses), 32'd0);
    check32("midreset result after", result, 32'h0);
    run("post-reset 1/2", 32'h3f800000, 32'h40000000, 32'h3f000000);

    run("denorm/0",  32'h00000001, 32'h00000000, 32'h7F800000);
    run("0/0",       32'h00000000, 32'h00000000, 32'h7FC00000);
    run("inf/inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000);
    run("nan/1",     32'h7FC00001, 32'h3f800000, 32'h7FC00000);
    run("-0/2",      32'h80000000, 32'h40000000, 32'h80000000);
    run("overflow",  32'h7f7fffff, 32'h3f000000, 32'h7F800000);
    run("underflow", 32'h00800000, 32'h40000000, 32'h00000000);
    run("1/3 rne",   32'h3f800000, 32'h40400000, 32'h3eaaaaab);

    // valid held high while busy must not disturb the accepted operands.
    @(negedge clk);
    din1  = 32'h3f800000;
    din2  = 32'h40400000;
    valid = 1'b1;
    @(negedge clk);
    din1 = 32'h40000000;
    din2 = 32'h3f800000;
    repeat (20) @(negedge clk);
    valid = 1'b0;
    wait_ready(n);
    check32("busy latency", 32'(n), 32'd10);
    check32("busy result", result, 32'h3eaaaaab);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check32("busy extra pulses", 32'(pulses), 32'd0);
    check32("busy result hold", result, 32'h3eaaaaab);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
